sobel_rgb_stream_src: RTL and testbench

- Upstream transmitter for the Sobel filter's three pixel input channels (r, g, b). It drives the consumer side of the busy/vld/data point-to-point protocol.
- Fetches 24-bit RGB pixels in row-major order from a synchronous-read pixel memory and presents each colour byte on its own channel.
- Advances to the next pixel only after all three channels have completed a transfer.
- Sits between the frame buffer and the filter's channel inputs, and is started once per frame.

---
 rtl/sobel_rgb_stream_src.sv | 130 +++++++++++++
 tb/tb_sobel_rgb_stream_src.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_rgb_stream_src.sv
// Frame streamer: reads RGB pixels row-major from a sync-read memory and
// hands each colour byte to its own busy/vld/data channel.
module sobel_rgb_stream_src #(
    parameter  int                IMG_W     = 256,
    parameter  int                IMG_H     = 256,
    parameter  int                ADDR_W    = 16,
    parameter  logic [ADDR_W-1:0] BASE_ADDR = '0,
    localparam int                XW        = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int                YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              start,
    output logic              active,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic              o_r_vld,
    output logic              o_g_vld,
    output logic              o_b_vld,
    output logic [7:0]        o_r_data,
    output logic [7:0]        o_g_data,
    output logic [7:0]        o_b_data,
    input  logic              o_r_busy,
    input  logic              o_g_busy,
    input  logic              o_b_busy,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t state;
    logic   pend_r, pend_g, pend_b;
    logic   keep_r, keep_g, keep_b;
    logic   send_done;
    logic   last_pix;

    // A pending flag survives an edge only while its consumer stalls it.
    assign keep_r    = pend_r & o_r_busy;
    assign keep_g    = pend_g & o_g_busy;
    assign keep_b    = pend_b & o_b_busy;
    assign send_done = ~(keep_r | keep_g | keep_b);
    assign last_pix  = (pix_x == X_LAST) && (pix_y == Y_LAST);

    assign o_r_vld = pend_r;
    assign o_g_vld = pend_g;
    assign o_b_vld = pend_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            active   <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            o_r_data <= '0;
            o_g_data <= '0;
            o_b_data <= '0;
            pend_r   <= 1'b0;
            pend_g   <= 1'b0;
            pend_b   <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
        end else begin
            // NOTE: pulse outputs default low here with non-blocking writes, so
            // any branch below may raise them for exactly one cycle.
            done   <= 1'b0;
            mem_rd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        active   <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= BASE_ADDR;
                        pix_x    <= '0;
                        pix_y    <= '0;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    {o_r_data, o_g_data, o_b_data} <= mem_rdata;
                    pend_r <= 1'b1;
                    pend_g <= 1'b1;
                    pend_b <= 1'b1;
                    state  <= S_SEND;
                end
                S_SEND: begin
                    pend_r <= keep_r;
                    pend_g <= keep_g;
                    pend_b <= keep_b;
                    if (send_done) begin
                        if (last_pix) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            // mem_addr is the running linear pixel index.
                            state    <= S_FETCH;
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            if (pix_x == X_LAST) begin
                                pix_x <= '0;
                                pix_y <= pix_y + YW'(1);
                            end else begin
                                pix_x <= pix_x + XW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    active <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_rgb_stream_src.sv
// Bench for sobel_rgb_stream_src: directed 4x2 scenarios plus a randomised
// 256x16 frame scored against a per-channel byte-stream model.
module tb_sobel_rgb_stream_src;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- small instance: 4x2, base 0 ----------------
    logic        s_rst = 1'b1, s_start = 1'b0;
    logic        s_active, s_done, s_mem_rd;
    logic [15:0] s_mem_addr;
    logic [23:0] s_rdata = '0;
    logic        s_r_vld, s_g_vld, s_b_vld;
    logic [7:0]  s_r_data, s_g_data, s_b_data;
    logic        s_r_busy = 1'b0, s_g_busy = 1'b0, s_b_busy = 1'b0;
    logic [1:0]  s_px;
    logic [0:0]  s_py;

    sobel_rgb_stream_src #(.IMG_W(4), .IMG_H(2), .ADDR_W(16), .BASE_ADDR(16'h0000)) u_small (
        .i_clk(clk), .i_rst(s_rst), .start(s_start), .active(s_active), .done(s_done),
        .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_rdata(s_rdata),
        .o_r_vld(s_r_vld), .o_g_vld(s_g_vld), .o_b_vld(s_b_vld),
        .o_r_data(s_r_data), .o_g_data(s_g_data), .o_b_data(s_b_data),
        .o_r_busy(s_r_busy), .o_g_busy(s_g_busy), .o_b_busy(s_b_busy),
        .pix_x(s_px), .pix_y(s_py)
    );

    always @(posedge clk) if (s_mem_rd) s_rdata <= {s_mem_addr[7:0], s_mem_addr[7:0] + 8'd16, s_mem_addr[7:0] + 8'd32};

    // ---------------- big instance: 256x16, base 0x1000 ----------------
    localparam int            B_W = 256, B_H = 16, B_N = B_W * B_H;
    localparam logic [15:0]   B_BASE = 16'h1000;
    logic        b_rst = 1'b1, b_start = 1'b0;
    logic        b_active, b_done, b_mem_rd;
    logic [15:0] b_mem_addr;
    logic [23:0] b_rdata = '0;
    logic        b_r_vld, b_g_vld, b_b_vld;
    logic [7:0]  b_r_data, b_g_data, b_b_data;
    logic        b_r_busy = 1'b0, b_g_busy = 1'b0, b_b_busy = 1'b0;
    logic [7:0]  b_px;
    logic [3:0]  b_py;

    sobel_rgb_stream_src #(.IMG_W(B_W), .IMG_H(B_H), .ADDR_W(16), .BASE_ADDR(B_BASE)) u_big (
        .i_clk(clk), .i_rst(b_rst), .start(b_start), .active(b_active), .done(b_done),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
        .o_r_vld(b_r_vld), .o_g_vld(b_g_vld), .o_b_vld(b_b_vld),
        .o_r_data(b_r_data), .o_g_data(b_g_data), .o_b_data(b_b_data),
        .o_r_busy(b_r_busy), .o_g_busy(b_g_busy), .o_b_busy(b_b_busy),
        .pix_x(b_px), .pix_y(b_py)
    );

    function automatic logic [23:0] big_mem(input logic [15:0] a);
        return {a[7:0], a[15:8] ^ 8'hA5, a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8]};
    endfunction

    always @(posedge clk) if (b_mem_rd) b_rdata <= big_mem(b_mem_addr);

    // ---------------- small-instance observation ----------------
    logic [7:0]  s_rq[$], s_gq[$], s_bq[$];
    logic [15:0] s_aq[$];
    int s_k, s_done_cnt, s_done_k, s_first_vld_k, s_first_rd_k;

    task automatic s_clear();
        s_rq.delete(); s_gq.delete(); s_bq.delete(); s_aq.delete();
        s_k = 0; s_done_cnt = 0; s_done_k = -1; s_first_vld_k = -1; s_first_rd_k = -1;
    endtask

    // Records this cycle's transfers/fetches, advances one clock, then checks
    // that every channel stalled before the edge kept vld and data.
    task automatic s_cycle();
        logic rs, gs, bs;
        logic [7:0] rd, gd, bd;
        if (s_r_vld && !s_r_busy) s_rq.push_back(s_r_data);
        if (s_g_vld && !s_g_busy) s_gq.push_back(s_g_data);
        if (s_b_vld && !s_b_busy) s_bq.push_back(s_b_data);
        if (s_mem_rd) begin
            check("s_fetch_addr", s_mem_addr, s_aq.size());
            check("s_fetch_x", s_px, s_aq.size() % 4);
            check("s_fetch_y", s_py, s_aq.size() / 4);
            s_aq.push_back(s_mem_addr);
            if (s_first_rd_k < 0) s_first_rd_k = s_k;
        end
        if (s_first_vld_k < 0 && (s_r_vld || s_g_vld || s_b_vld)) s_first_vld_k = s_k;
        if (s_done) begin s_done_cnt++; s_done_k = s_k; end
        rs = s_r_vld && s_r_busy && !s_rst; rd = s_r_data;
        gs = s_g_vld && s_g_busy && !s_rst; gd = s_g_data;
        bs = s_b_vld && s_b_busy && !s_rst; bd = s_b_data;
        tick();
        s_k++;
        if (rs) begin check("s_r_hold_vld", s_r_vld, 1); check("s_r_hold_data", s_r_data, rd); end
        if (gs) begin check("s_g_hold_vld", s_g_vld, 1); check("s_g_hold_data", s_g_data, gd); end
        if (bs) begin check("s_b_hold_vld", s_b_vld, 1); check("s_b_hold_data", s_b_data, bd); end
    endtask

    task automatic s_check_frame();
        check("s_r_count", s_rq.size(), 8);
        check("s_g_count", s_gq.size(), 8);
        check("s_b_count", s_bq.size(), 8);
        check("s_fetch_count", s_aq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < s_rq.size()) check("s_r_order", s_rq[i], i);
            if (i < s_gq.size()) check("s_g_order", s_gq[i], i + 16);
            if (i < s_bq.size()) check("s_b_order", s_bq[i], i + 32);
        end
        check("s_done_count", s_done_cnt, 1);
    endtask

    // ---------------- big-instance scoreboard state ----------------
    int b_nr, b_ng, b_nb, b_nf, b_done_cnt, b_cyc;
    logic [23:0] b_exp;
    logic b_rs, b_gs, b_bs;
    logic [7:0] b_rd, b_gd, b_bd;

    initial begin
        // Reset state
        tick(); tick();
        check("s_reset_active", s_active, 0);
        check("s_reset_done", s_done, 0);
        check("s_reset_mem_rd", s_mem_rd, 0);
        check("s_reset_addr", s_mem_addr, 0);
        check("s_reset_vld", {s_r_vld, s_g_vld, s_b_vld}, 0);
        check("s_reset_data", {s_r_data, s_g_data, s_b_data}, 0);
        check("s_reset_pix", {s_px, s_py}, 0);
        s_rst = 1'b0;

        // Full 4x2 frame, consumer always ready
        s_clear();
        s_start = 1'b1; s_cycle(); s_start = 1'b0;
        repeat (30) s_cycle();
        s_check_frame();
        check("s_first_rd_cycle", s_first_rd_k, 1);
        check("s_first_vld_cycle", s_first_vld_k, 3);
        check("s_done_cycle", s_done_k, 25);
        check("s_idle_active", s_active, 0);

        // Green stalled for 5 cycles at pixel 0
        s_clear();
        s_start = 1'b1; s_cycle(); s_start = 1'b0;
        s_cycle(); s_cycle();
        s_g_busy = 1'b1;
        check("skew_all_vld", {s_r_vld, s_g_vld, s_b_vld}, 3'b111);
        for (int j = 0; j < 5; j++) begin
            s_cycle();
            check("skew_r_dropped", s_r_vld, 0);
            check("skew_b_dropped", s_b_vld, 0);
            check("skew_g_held", s_g_vld, 1);
            check("skew_g_data", s_g_data, 16);
            check("skew_no_fetch", s_mem_rd, 0);
        end
        s_g_busy = 1'b0;
        s_cycle();
        check("skew_g_done", s_g_vld, 0);
        check("skew_fetch_px1", s_mem_rd, 1);
        check("skew_fetch_addr", s_mem_addr, 1);
        repeat (30) s_cycle();
        s_check_frame();

        // Row wrap, with a stray start during pixel 3
        s_clear();
        s_start = 1'b1; s_cycle(); s_start = 1'b0;
        while (s_k < 11) s_cycle();
        s_start = 1'b1; s_cycle(); s_start = 1'b0;
        check("wrap_send_px3", {s_px, s_py}, {2'd3, 1'b0});
        s_cycle();
        check("wrap_fetch", s_mem_rd, 1);
        check("wrap_addr", s_mem_addr, 4);
        check("wrap_x", s_px, 0);
        check("wrap_y", s_py, 1);
        repeat (20) s_cycle();
        s_check_frame();
        check("stray_done_cycle", s_done_k, 25);
        check("stray_no_restart", s_active, 0);

        // Reset during SEND with blue stalled; start alongside reset
        s_clear();
        s_start = 1'b1; s_cycle(); s_start = 1'b0;
        check("idle_start_fetch", s_mem_rd, 1);
        while (s_k < 9) s_cycle();
        s_b_busy = 1'b1;
        s_cycle();
        check("rst_pre_b_vld", s_b_vld, 1);
        s_rst = 1'b1; s_start = 1'b1;
        s_cycle();
        s_rst = 1'b0; s_start = 1'b0; s_b_busy = 1'b0;
        check("rst_vld", {s_r_vld, s_g_vld, s_b_vld}, 0);
        check("rst_active", s_active, 0);
        check("rst_done", s_done, 0);
        check("rst_pix", {s_px, s_py}, 0);
        s_cycle();
        check("rst_start_ignored", s_active, 0);
        check("rst_start_no_fetch", s_mem_rd, 0);
        s_clear();
        s_start = 1'b1; s_cycle(); s_start = 1'b0;
        check("post_rst_fetch", s_mem_rd, 1);
        check("post_rst_addr", s_mem_addr, 0);
        repeat (30) s_cycle();
        s_check_frame();

        // Randomised busy over a 256x16 frame
        b_rst = 1'b0;
        tick();
        check("b_reset_active", b_active, 0);
        check("b_reset_vld", {b_r_vld, b_g_vld, b_b_vld}, 0);
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_nr = 0; b_ng = 0; b_nb = 0; b_nf = 0; b_done_cnt = 0; b_cyc = 0;
        while (b_done_cnt == 0 && b_cyc < 40000) begin
            b_r_busy = ($urandom_range(0, 1) == 1);
            b_g_busy = ($urandom_range(0, 1) == 1);
            b_b_busy = ($urandom_range(0, 1) == 1);
            if (b_mem_rd) begin
                check("b_fetch_addr", b_mem_addr, 32'(B_BASE) + b_nf);
                check("b_fetch_x", b_px, b_nf % B_W);
                check("b_fetch_y", b_py, b_nf / B_W);
                b_nf++;
            end
            if (b_r_vld && !b_r_busy) begin
                b_exp = big_mem(16'(32'(B_BASE) + b_nr));
                check("b_r_data", b_r_data, b_exp[23:16]); b_nr++;
            end
            if (b_g_vld && !b_g_busy) begin
                b_exp = big_mem(16'(32'(B_BASE) + b_ng));
                check("b_g_data", b_g_data, b_exp[15:8]); b_ng++;
            end
            if (b_b_vld && !b_b_busy) begin
                b_exp = big_mem(16'(32'(B_BASE) + b_nb));
                check("b_b_data", b_b_data, b_exp[7:0]); b_nb++;
            end
            if (b_done) b_done_cnt++;
            b_rs = b_r_vld && b_r_busy; b_rd = b_r_data;
            b_gs = b_g_vld && b_g_busy; b_gd = b_g_data;
            b_bs = b_b_vld && b_b_busy; b_bd = b_b_data;
            tick();
            b_cyc++;
            if (b_rs) begin check("b_r_hold_vld", b_r_vld, 1); check("b_r_hold_data", b_r_data, b_rd); end
            if (b_gs) begin check("b_g_hold_vld", b_g_vld, 1); check("b_g_hold_data", b_g_data, b_gd); end
            if (b_bs) begin check("b_b_hold_vld", b_b_vld, 1); check("b_b_hold_data", b_b_data, b_bd); end
        end
        check("b_done_seen", b_done_cnt, 1);
        check("b_r_count", b_nr, B_N);
        check("b_g_count", b_ng, B_N);
        check("b_b_count", b_nb, B_N);
        check("b_fetch_count", b_nf, B_N);
        check("b_done_single", b_done, 0);
        check("b_active_after", b_active, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
